// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR front end, the filter and the bench.
package fir_pkg;
    localparam int NB         = 8;
    localparam int NTAPS      = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_COEF = 2'd1,
        STREAM    = 2'd2
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy, synchronous flush and
// a combinational head so the caller can register it on pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against a caller pushing into a full or popping an empty buffer.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/fir_in_stage.sv
// Byte-stream front end for the Fir core: the first NTAPS bytes after LOAD become
// coefficients, later bytes are buffered and issued as DOUT/VOUT samples.
module fir_in_stage #(
    parameter int NB         = fir_pkg::NB,
    parameter int NTAPS      = fir_pkg::NTAPS,
    parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      LOAD,
    input  logic [NB-1:0]             S_DATA,
    input  logic                      S_VALID,
    output logic                      S_READY,
    input  logic                      STALL,
    output logic [NB-1:0]             DOUT,
    output logic                      VOUT,
    output logic [NB-1:0]             B0,
    output logic [NB-1:0]             B1,
    output logic [NB-1:0]             B2,
    output logic [NB-1:0]             B3,
    output logic [NB-1:0]             B4,
    output logic [NB-1:0]             B5,
    output logic [NB-1:0]             B6,
    output logic [NB-1:0]             B7,
    output logic [NB-1:0]             B8,
    output logic                      COEF_OK,
    output logic [fir_pkg::CNT_W-1:0] SAMPLE_CNT
);
    import fir_pkg::*;

    localparam int            IDX_W    = $clog2(NTAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [NB-1:0]     r_coef [NTAPS];
    logic [NB-1:0]     r_dout;
    logic              r_vout;
    logic              r_coef_ok;
    logic [CNT_W-1:0]  r_sample_cnt;

    logic              w_s_ready;
    logic              w_coef_we;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [NB-1:0]     w_fifo_head;

    always_ff @(posedge CLK) begin
        if (!RST_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // LOAD overrides every state and swallows any byte offered on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_coef_we    = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_s_ready = 1'b0;
            end
            LOAD_COEF: begin
                w_s_ready = 1'b1;
                w_coef_we = S_VALID && !LOAD;
                if (w_coef_we && (r_idx == LAST_IDX)) w_state_next = STREAM;
            end
            STREAM: begin
                w_s_ready = !w_fifo_full;
                w_push    = S_VALID && !w_fifo_full && !LOAD;
                w_pop     = !w_fifo_empty && !STALL && !LOAD;
            end
            default: w_state_next = IDLE;
        endcase
        if (LOAD) w_state_next = LOAD_COEF;
    end

    sync_fifo #(
        .WIDTH (NB),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .i_rst_n (RST_n),
        .i_flush (LOAD),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (S_DATA),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_idx        <= '0;
            r_dout       <= '0;
            r_vout       <= 1'b0;
            r_coef_ok    <= 1'b0;
            r_sample_cnt <= '0;
        end else if (LOAD) begin
            r_idx        <= '0;
            r_vout       <= 1'b0;
            r_coef_ok    <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_vout <= w_pop;
            if (w_pop) begin
                r_dout       <= w_fifo_head;
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (w_coef_we) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == LAST_IDX) r_coef_ok <= 1'b1;
            end
        end
    end

    // Coefficients survive a reload until their own slot is rewritten.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
            always_ff @(posedge CLK) begin
                if (!RST_n)
                    r_coef[gi] <= '0;
                else if (w_coef_we && (r_idx == IDX_W'(gi)))
                    r_coef[gi] <= S_DATA;
            end
        end
    endgenerate

    assign S_READY    = w_s_ready;
    assign DOUT       = r_dout;
    assign VOUT       = r_vout;
    assign COEF_OK    = r_coef_ok;
    assign SAMPLE_CNT = r_sample_cnt;
    assign B0 = r_coef[0];
    assign B1 = r_coef[1];
    assign B2 = r_coef[2];
    assign B3 = r_coef[3];
    assign B4 = r_coef[4];
    assign B5 = r_coef[5];
    assign B6 = r_coef[6];
    assign B7 = r_coef[7];
    assign B8 = r_coef[8];
endmodule

// File: tb/tb_fir_in_stage.sv
// Scenario bench for fir_in_stage; a queue-based transaction model tracks expected outputs.
module tb_fir_in_stage;
    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        LOAD = 1'b0;
    logic [7:0]  S_DATA = '0;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic        STALL = 1'b0;
    logic [7:0]  DOUT;
    logic        VOUT;
    logic [7:0]  B0, B1, B2, B3, B4, B5, B6, B7, B8;
    logic        COEF_OK;
    logic [15:0] SAMPLE_CNT;
    logic [7:0]  b_out [9];

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 = waiting, 1 = collecting coefficients, 2 = streaming.
    int          m_mode;
    int          m_idx;
    logic [7:0]  m_b [9];
    logic [7:0]  m_q [$];
    logic [7:0]  m_dout;
    logic        m_vout;
    logic        m_ok;
    logic [15:0] m_cnt;
    logic        m_acc;

    always #5 CLK = ~CLK;

    fir_in_stage dut (
        .CLK(CLK), .RST_n(RST_n), .LOAD(LOAD), .S_DATA(S_DATA), .S_VALID(S_VALID),
        .S_READY(S_READY), .STALL(STALL), .DOUT(DOUT), .VOUT(VOUT),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
        .COEF_OK(COEF_OK), .SAMPLE_CNT(SAMPLE_CNT)
    );

    assign b_out[0] = B0; assign b_out[1] = B1; assign b_out[2] = B2;
    assign b_out[3] = B3; assign b_out[4] = B4; assign b_out[5] = B5;
    assign b_out[6] = B6; assign b_out[7] = B7; assign b_out[8] = B8;

    function automatic bit model_ready();
        if (m_mode == 1) return 1'b1;
        if (m_mode == 2) return (m_q.size() < 4);
        return 1'b0;
    endfunction

    task automatic do_reset();
        RST_n = 1'b0; LOAD = 1'b0; S_VALID = 1'b0; STALL = 1'b0;
        m_mode = 0; m_idx = 0; m_q.delete();
        for (int i = 0; i < 9; i++) m_b[i] = 8'h00;
        m_dout = 8'h00; m_vout = 1'b0; m_ok = 1'b0; m_cnt = 16'd0; m_acc = 1'b0;
        @(posedge CLK); #1;
        RST_n = 1'b1;
    endtask

    task automatic cycle(input logic ld, input logic v, input logic [7:0] d, input logic st);
        bit pop;
        LOAD = ld; S_VALID = v; S_DATA = d; STALL = st;
        m_acc = v && model_ready() && !ld;
        if (ld) begin
            m_mode = 1; m_idx = 0; m_q.delete();
            m_vout = 1'b0; m_ok = 1'b0; m_cnt = 16'd0;
        end else if (m_mode == 1) begin
            if (m_acc) begin
                m_b[m_idx] = d;
                m_idx++;
                if (m_idx == 9) begin m_mode = 2; m_ok = 1'b1; end
            end
        end else if (m_mode == 2) begin
            pop = (m_q.size() > 0) && !st;
            m_vout = pop;
            if (pop) begin m_dout = m_q.pop_front(); m_cnt++; end
            if (m_acc) m_q.push_back(d);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (S_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", S_READY); end
        checks++; if (VOUT !== 1'b0) begin failures++; $display("FAIL reset_vout got=%b exp=0", VOUT); end
        checks++; if (DOUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
        checks++; if (COEF_OK !== 1'b0) begin failures++; $display("FAIL reset_coef_ok got=%b exp=0", COEF_OK); end
        checks++; if (SAMPLE_CNT !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", SAMPLE_CNT); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (b_out[i] !== 8'h00) begin failures++; $display("FAIL reset_b%0d got=%h exp=00", i, b_out[i]); end
        end
        for (int j = 0; j < 5; j++) begin
            cycle(1'b0, 1'b1, 8'h55, 1'b0);
            checks++; if (S_READY !== 1'b0) begin failures++; $display("FAIL idle_ready cyc=%0d got=%b exp=0", j, S_READY); end
            checks++; if (B0 !== 8'h00 || VOUT !== 1'b0) begin failures++; $display("FAIL idle_no_accept cyc=%0d b0=%h vout=%b exp=00/0", j, B0, VOUT); end
        end
        $display("test_reset done");
    endtask

    task automatic test_load_stream();
        logic [7:0] exp_dout [5];
        logic       exp_vout [5];
        exp_vout[0] = 1'b0; exp_vout[1] = 1'b1; exp_vout[2] = 1'b1; exp_vout[3] = 1'b1; exp_vout[4] = 1'b0;
        exp_dout[0] = 8'h00; exp_dout[1] = 8'h10; exp_dout[2] = 8'h11; exp_dout[3] = 8'h12; exp_dout[4] = 8'h12;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 8'(i + 1), 1'b0);
            checks++; if (b_out[i] !== 8'(i + 1)) begin failures++; $display("FAIL coef_b%0d got=%h exp=%h", i, b_out[i], 8'(i + 1)); end
            checks++; if (COEF_OK !== (i == 8)) begin failures++; $display("FAIL coef_ok idx=%0d got=%b exp=%b", i, COEF_OK, (i == 8)); end
        end
        for (int j = 0; j < 5; j++) begin
            cycle(1'b0, j < 3, 8'(8'h10 + j), 1'b0);
            checks++; if (VOUT !== exp_vout[j]) begin failures++; $display("FAIL first_vout cyc=%0d got=%b exp=%b", j, VOUT, exp_vout[j]); end
            checks++; if (DOUT !== exp_dout[j]) begin failures++; $display("FAIL first_dout cyc=%0d got=%h exp=%h", j, DOUT, exp_dout[j]); end
        end
        checks++; if (SAMPLE_CNT !== 16'd3) begin failures++; $display("FAIL first_cnt got=%0d exp=3", SAMPLE_CNT); end
        $display("test_load_stream done");
    endtask

    task automatic test_stall_backpressure();
        logic [7:0] data [6];
        logic [7:0] got [$];
        int sent = 0;
        for (int i = 0; i < 6; i++) data[i] = 8'($urandom);
        for (int j = 0; j < 6; j++) begin
            cycle(1'b0, 1'b1, data[sent], 1'b1);
            if (m_acc) sent++;
            checks++; if (S_READY !== (sent < 4)) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", j, S_READY, (sent < 4)); end
            checks++; if (VOUT !== 1'b0) begin failures++; $display("FAIL stall_vout cyc=%0d got=%b exp=0", j, VOUT); end
        end
        checks++; if (sent !== 4) begin failures++; $display("FAIL stall_accepts got=%0d exp=4", sent); end
        for (int j = 0; j < 12; j++) begin
            cycle(1'b0, sent < 6, data[sent % 6], 1'b0);
            if (m_acc) sent++;
            if (VOUT === 1'b1) got.push_back(DOUT);
            checks++; if (VOUT !== m_vout || DOUT !== m_dout) begin failures++; $display("FAIL drain cyc=%0d got=%b/%h exp=%b/%h", j, VOUT, DOUT, m_vout, m_dout); end
        end
        checks++; if (got.size() !== 6) begin failures++; $display("FAIL drain_count got=%0d exp=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i] !== data[i]) begin failures++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got[i], data[i]); end
        end
        $display("test_stall_backpressure done");
    endtask

    task automatic test_random_stream();
        for (int j = 0; j < 300; j++) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
            checks++;
            if (VOUT !== m_vout || DOUT !== m_dout || S_READY !== model_ready() || SAMPLE_CNT !== m_cnt || COEF_OK !== m_ok) begin
                failures++;
                $display("FAIL rand cyc=%0d got v=%b d=%h r=%b c=%0d exp v=%b d=%h r=%b c=%0d",
                         j, VOUT, DOUT, S_READY, SAMPLE_CNT, m_vout, m_dout, model_ready(), m_cnt);
            end
        end
        for (int j = 0; j < 6; j++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        $display("test_random_stream done");
    endtask

    task automatic test_reload();
        logic [7:0] nb [9];
        logic [7:0] old_b0;
        old_b0 = m_b[0];
        for (int i = 0; i < 9; i++) nb[i] = 8'($urandom);
        nb[0] = 8'h3C;
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        checks++; if (VOUT !== 1'b0) begin failures++; $display("FAIL reload_vout got=%b exp=0", VOUT); end
        checks++; if (COEF_OK !== 1'b0) begin failures++; $display("FAIL reload_coef_ok got=%b exp=0", COEF_OK); end
        checks++; if (SAMPLE_CNT !== 16'd0) begin failures++; $display("FAIL reload_cnt got=%0d exp=0", SAMPLE_CNT); end
        checks++; if (B0 !== 8'h01 || B0 !== old_b0) begin failures++; $display("FAIL reload_b0_kept got=%h exp=01", B0); end
        checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL reload_ready got=%b exp=1", S_READY); end
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, nb[i], 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++; if (b_out[i] !== nb[i]) begin failures++; $display("FAIL reload_b%0d got=%h exp=%h", i, b_out[i], nb[i]); end
        end
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            checks++; if (VOUT !== 1'b0) begin failures++; $display("FAIL reload_flushed cyc=%0d got=%b exp=0", j, VOUT); end
        end
        checks++; if (COEF_OK !== 1'b1) begin failures++; $display("FAIL reload_coef_ok_set got=%b exp=1", COEF_OK); end
        $display("test_reload done");
    endtask

    task automatic test_counter_wrap();
        int sent = 0;
        int pulses = 0;
        int bad = 0;
        for (int j = 0; j < 65600 && pulses < 65537; j++) begin
            cycle(1'b0, sent < 65537, 8'($urandom), 1'b0);
            if (m_acc) sent++;
            if (VOUT === 1'b1) pulses++;
            if (VOUT !== m_vout || DOUT !== m_dout) bad++;
        end
        checks++; if (pulses !== 65537) begin failures++; $display("FAIL wrap_pulses got=%0d exp=65537", pulses); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_stream got=%0d_bad_cycles exp=0", bad); end
        checks++; if (SAMPLE_CNT !== 16'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", SAMPLE_CNT); end
        $display("test_counter_wrap done");
    endtask

    task automatic test_mid_load_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
        checks++; if (B4 !== m_b[4] || B4 === 8'h00) begin failures++; $display("FAIL midload_b4 got=%h exp=%h", B4, m_b[4]); end
        do_reset();
        for (int i = 0; i < 9; i++) begin
            checks++; if (b_out[i] !== 8'h00) begin failures++; $display("FAIL midrst_b%0d got=%h exp=00", i, b_out[i]); end
        end
        checks++; if (S_READY !== 1'b0 || COEF_OK !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b/%b exp=0/0", S_READY, COEF_OK); end
        for (int j = 0; j < 2; j++) begin
            cycle(1'b0, 1'b1, 8'h77, 1'b0);
            checks++; if (S_READY !== 1'b0 || B0 !== 8'h00) begin failures++; $display("FAIL midrst_idle cyc=%0d got=%b/%h exp=0/00", j, S_READY, B0); end
        end
        $display("test_mid_load_reset done");
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_stall_backpressure();
        test_random_stream();
        test_reload();
        test_counter_wrap();
        test_mid_load_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_in_stage.md
# fir_in_stage

Synthesizable front end placed directly upstream of the `Fir` core. It accepts a byte stream on a valid/ready handshake and loads the first 9 bytes after a `LOAD` pulse into the coefficient outputs `B0..B8`. All following bytes are buffered in a small FIFO and presented to the filter as `DOUT`/`VOUT` samples. The block drives the filter's `DIN`, `VIN` and `B0..B8` from a real byte source, and it supports downstream stall and coefficient reload.

## Interface
Clocking and reset: one clock, `CLK`; reset `RST_n` is synchronous and active-low.

Parameters:
- `NB`, 8: sample and coefficient width.
- `NTAPS`, 9: number of coefficients. Fixed for the `B0..B8` port list.
- `FIFO_DEPTH`, 4: sample buffer depth. Must be a power of 2, ≥2.

Ports:
- `CLK` in 1: clock. All logic is sampled on the rising edge.
- `RST_n` in 1: synchronous, active-low reset.
- `LOAD` in 1: single-cycle pulse that starts a coefficient load.
- `S_DATA` in NB: input byte.
- `S_VALID` in 1: `S_DATA` is valid.
- `S_READY` out 1: block accepts a byte at this edge.
- `STALL` in 1: downstream hold. While high, no new sample is issued.
- `DOUT` out NB: sample to `Fir.DIN`.
- `VOUT` out 1: sample valid, to `Fir.VIN`.
- `B0`..`B8` out NB each: coefficients to the filter.
- `COEF_OK` out 1: all 9 coefficients are loaded and streaming is active.
- `SAMPLE_CNT` out 16: number of `VOUT` pulses issued since the last `LOAD`.

## Operation
- **Accept rule:** a byte is accepted on an edge where `S_VALID && S_READY`.
- **FSM states:** IDLE, LOAD_COEF, STREAM.
- **Reset:** FSM goes to IDLE. Coefficient index = 0, FIFO empty. Outputs: `S_READY`=0, `VOUT`=0, `DOUT`=0, `B0..B8`=0, `COEF_OK`=0, `SAMPLE_CNT`=0.
- **IDLE:**
  - `S_READY`=0.
  - `LOAD`=1 → LOAD_COEF, index ← 0.
- **LOAD_COEF:**
  - `S_READY`=1.
  - Each accepted byte is written to `B[index]` and index increments.
  - The accept at index 8 writes `B8`, then the FSM goes to STREAM and `COEF_OK` ← 1.
- **STREAM:**
  - `S_READY` = !full. Full is computed from the registered occupancy, so a push is refused when full even if a pop happens on the same edge.
  - Accepted bytes are pushed into the FIFO.
  - **Pop:** on each edge where the FIFO is non-empty and `STALL`=0, the head moves to `DOUT` and `VOUT` ← 1. Otherwise `VOUT` ← 0 and `DOUT` holds its last value.
  - A push and a pop on the same edge are both performed and occupancy is unchanged.
- **`LOAD` asserted in LOAD_COEF or STREAM:** the load restarts.
  - index ← 0, FIFO flushed.
  - `VOUT` ← 0, `COEF_OK` ← 0, `SAMPLE_CNT` ← 0.
  - `B0..B8` keep their old values until each one is overwritten.
  - A byte presented on the same edge as `LOAD` is dropped, because `LOAD` has priority.
- **Coefficient stability:** `B0..B8` change only on accepts in LOAD_COEF. They are stable throughout STREAM.
- **`SAMPLE_CNT`:** increments on every edge that sets `VOUT`=1. It wraps from 65535 to 0.
- **Reset mid-operation:** `RST_n`=0 on any edge gives the full reset state listed above, regardless of FSM state.

## Timing
- **Coefficient latency:** a byte accepted at edge k appears on `B[i]` after edge k.
- **`COEF_OK`:** rises after the edge that accepts the 9th byte.
- **Sample latency:** a byte accepted at edge k into an empty FIFO, with `STALL`=0, drives `DOUT` with `VOUT`=1 after edge k+1. That is a 2-edge latency from the handshake.
- **Throughput:** one sample per cycle sustained while `S_VALID`=1 and `STALL`=0.
- **`STALL`:** sampled at edge k. `VOUT`=0 after edge k and no data is lost. Issue resumes on the first edge with `STALL`=0.
- **`VOUT`:** is a registered output and is high for exactly one cycle per sample.

## Structure
- **Package `fir_pkg`:** holds `NB`, `NTAPS`, the FSM state enum (IDLE/LOAD_COEF/STREAM), and `CNT_W`=16. The package is shared with the filter and bench.
- **Sub-module `sync_fifo`:** parameterized by width and depth. It has a registered occupancy count and flags `full`/`empty`, and provides a synchronous `flush` input plus `push`/`pop`.
- **Top level:** contains the FSM, coefficient index counter, coefficient register bank, output register and `SAMPLE_CNT`.

## Test plan
- **Reset:** after reset, all outputs are 0 and `S_READY`=0. Drive `S_VALID`=1 with data 0x55 for 5 cycles and check nothing is accepted.
- **Load and stream:**
  - Pulse `LOAD`, then stream bytes 0x01..0x09 back-to-back. Check `B0`=0x01 … `B8`=0x09, and that `COEF_OK` rises after the 9th accept.
  - Then send 0x10, 0x11, 0x12. Check `VOUT` pulses with `DOUT`=0x10, 0x11, 0x12, each 2 edges after its accept, and `SAMPLE_CNT`=3.
- **Stall and backpressure:**
  - Hold `STALL`=1 while pushing 6 bytes. Check `S_READY` drops after 4 accepts and `VOUT` stays 0.
  - Release `STALL`. Check 4 samples are issued in order, then the remaining 2, with no loss or duplicate.
- **Reload in STREAM:**
  - With 3 bytes buffered, pulse `LOAD` together with `S_VALID`=1, data 0xAA. Check: FIFO flushed, `VOUT`=0, `COEF_OK`=0, `SAMPLE_CNT`=0, and 0xAA not written to `B0`.
  - Then load 9 new bytes and check the new `B` values.
- **Counter wrap:** stream 65537 samples and check `SAMPLE_CNT`=1.
- **Mid-load reset:** after 5 coefficient accepts, drive `RST_n`=0 for 1 cycle. Check `B0..B4` return to 0, the FSM is in IDLE and `S_READY`=0.
